// File: rtl/bsg_dmc_ui_adapter.sv
// Burst request/response adapter in front of the DRAM controller UI (app_*) port.
// Optional protocol checker is enabled by defining BSG_DMC_UI_ADAPTER_CHECK_EN.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

package bsg_dmc_pkg;
    typedef enum logic [2:0] {
        WR = 3'b000,
        RD = 3'b001
    } app_cmd_e;
endpackage

module bsg_dmc_ui_adapter
    import bsg_dmc_pkg::*;
#(
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 32,
    parameter int burst_data_width_p = 128
) (
    input  logic                            ui_clk_i,
    input  logic                            ui_reset_n_i,
    // Request/response: a transfer happens on req_v_i & req_ready_o; the
    // response is consumed by resp_yumi_i, which is legal only while resp_v_o=1.
    input  logic                            req_v_i,
    output logic                            req_ready_o,
    input  logic                            req_write_i,
    input  logic [ui_addr_width_p-1:0]      req_addr_i,
    input  logic [burst_data_width_p-1:0]   req_data_i,
    input  logic [burst_data_width_p/8-1:0] req_mask_i,
    output logic                            resp_v_o,
    output logic [burst_data_width_p-1:0]   resp_data_o,
    input  logic                            resp_yumi_i,
    output logic [ui_addr_width_p-1:0]      app_addr_o,
    output app_cmd_e                        app_cmd_o,
    output logic                            app_en_o,
    input  logic                            app_rdy_i,
    output logic                            app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]      app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0]    app_wdf_mask_o,
    output logic                            app_wdf_end_o,
    input  logic                            app_wdf_rdy_i,
    input  logic                            app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]      app_rd_data_i,
    input  logic                            app_rd_data_end_i,
    output logic                            error_o,
    output logic [1:0]                      state_o
);

    localparam int beats_lp  = burst_data_width_p / ui_data_width_p;
    localparam int cnt_w_lp  = `BSG_SAFE_CLOG2(beats_lp);
    localparam int mask_w_lp = ui_data_width_p / 8;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(beats_lp - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [cnt_w_lp-1:0]             wcnt_q, wcnt_d;
    logic [cnt_w_lp-1:0]             rcnt_q, rcnt_d;
    logic                            cmd_done_q, cmd_done_d;
    logic                            wdone_q, wdone_d;
    logic                            app_en_q, app_en_d;
    app_cmd_e                        app_cmd_q, app_cmd_d;
    logic                            wren_q, wren_d;
    logic                            wend_q, wend_d;
    logic                            resp_v_q, resp_v_d;
    logic                            ready_q, ready_d;

    logic [ui_addr_width_p-1:0]      addr_q, addr_d;
    logic [burst_data_width_p-1:0]   wdata_q, wdata_d;
    logic [burst_data_width_p/8-1:0] wmask_q, wmask_d;
    logic [burst_data_width_p-1:0]   resp_buf_q, resp_buf_d;

    logic req_xfer;
    logic capture_en;
    logic rd_last;

    assign req_xfer   = req_v_i & ready_q;
    assign capture_en = (state_q == RD_CMD) || (state_q == RD_WAIT);
    assign rd_last    = (rcnt_q == last_cnt_lp);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        cmd_done_d = cmd_done_q;
        wdone_d    = wdone_q;
        app_en_d   = app_en_q;
        app_cmd_d  = app_cmd_q;
        wren_d     = wren_q;
        wend_d     = wend_q;
        resp_v_d   = resp_v_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        resp_buf_d = resp_buf_q;

        unique case (state_q)
            IDLE: begin
                if (req_xfer) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_data_i;
                    wmask_d  = req_mask_i;
                    app_en_d = 1'b1;
                    wcnt_d   = '0;
                    rcnt_d   = '0;
                    if (req_write_i) begin
                        state_d    = WRITE;
                        app_cmd_d  = WR;
                        wren_d     = 1'b1;
                        wend_d     = (beats_lp == 1);
                        cmd_done_d = 1'b0;
                        wdone_d    = 1'b0;
                    end else begin
                        state_d   = RD_CMD;
                        app_cmd_d = RD;
                    end
                end
            end
            WRITE: begin
                // Command and data channels run independently; leave once both are done.
                if (app_en_q && app_rdy_i) begin
                    app_en_d   = 1'b0;
                    cmd_done_d = 1'b1;
                end
                if (wren_q && app_wdf_rdy_i) begin
                    if (wend_q) begin
                        wren_d  = 1'b0;
                        wend_d  = 1'b0;
                        wdone_d = 1'b1;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        wdata_d = wdata_q >> ui_data_width_p;
                        wmask_d = wmask_q >> mask_w_lp;
                        wend_d  = (wcnt_d == last_cnt_lp);
                    end
                end
                if (cmd_done_q && wdone_q) begin
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (app_en_q && app_rdy_i) begin
                    app_en_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_d = RD_WAIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read beats may land before the command handshake, so capture spans both read states.
        if (capture_en && app_rd_data_valid_i) begin
            resp_buf_d[rcnt_q*ui_data_width_p +: ui_data_width_p] = app_rd_data_i;
            if (rd_last) begin
                rcnt_d   = '0;
                resp_v_d = 1'b1;
                app_en_d = 1'b0;
                state_d  = IDLE;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        if (resp_v_q && resp_yumi_i) begin
            resp_v_d = 1'b0;
        end

        ready_d = (state_d == IDLE) && !resp_v_d;
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            cmd_done_q <= 1'b0;
            wdone_q    <= 1'b0;
            app_en_q   <= 1'b0;
            app_cmd_q  <= WR;
            wren_q     <= 1'b0;
            wend_q     <= 1'b0;
            resp_v_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            cmd_done_q <= cmd_done_d;
            wdone_q    <= wdone_d;
            app_en_q   <= app_en_d;
            app_cmd_q  <= app_cmd_d;
            wren_q     <= wren_d;
            wend_q     <= wend_d;
            resp_v_q   <= resp_v_d;
            ready_q    <= ready_d;
        end
    end

    always_ff @(posedge ui_clk_i) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        wmask_q    <= wmask_d;
        resp_buf_q <= resp_buf_d;
    end

`ifdef BSG_DMC_UI_ADAPTER_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (app_rd_data_valid_i) begin
            if (!capture_en) begin
                error_d = 1'b1;
            end else if (app_rd_data_end_i != rd_last) begin
                error_d = 1'b1;
            end
        end
        if (resp_yumi_i && !resp_v_q) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge ui_clk_i or negedge ui_reset_n_i) begin
        if (!ui_reset_n_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    logic unused_rd_end;
    assign unused_rd_end = app_rd_data_end_i;
    assign error_o       = 1'b0;
`endif

    // The write path presents the low slice of a shift register, so beat data is always a flop output.
    assign req_ready_o    = ready_q;
    assign resp_v_o       = resp_v_q;
    assign resp_data_o    = resp_buf_q;
    assign app_addr_o     = addr_q;
    assign app_cmd_o      = app_cmd_q;
    assign app_en_o       = app_en_q;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_data_o = wdata_q[ui_data_width_p-1:0];
    assign app_wdf_mask_o = wmask_q[mask_w_lp-1:0];
    assign app_wdf_end_o  = wend_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_bsg_dmc_ui_adapter.sv
// Self-checking bench for bsg_dmc_ui_adapter: directed steps plus randomized
// transactions scored against a burst-level model of the UI traffic.
module tb_bsg_dmc_ui_adapter;
    import bsg_dmc_pkg::*;

    localparam int AW    = 28;
    localparam int DW    = 32;
    localparam int BW    = 128;
    localparam int BEATS = BW / DW;
    localparam int MW    = DW / 8;
`ifdef BSG_DMC_UI_ADAPTER_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            req_v_i = 0, req_ready_o, req_write_i = 0;
    logic [AW-1:0]   req_addr_i = '0;
    logic [BW-1:0]   req_data_i = '0;
    logic [BW/8-1:0] req_mask_i = '0;
    logic            resp_v_o, resp_yumi_i = 0;
    logic [BW-1:0]   resp_data_o;
    logic [AW-1:0]   app_addr_o;
    app_cmd_e        app_cmd_o;
    logic            app_en_o, app_rdy_i = 0;
    logic            app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i = 0;
    logic [DW-1:0]   app_wdf_data_o;
    logic [MW-1:0]   app_wdf_mask_o;
    logic            app_rd_data_valid_i = 0, app_rd_data_end_i = 0;
    logic [DW-1:0]   app_rd_data_i = '0;
    logic            error_o;
    logic [1:0]      state_o;

    bsg_dmc_ui_adapter #(.ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_data_width_p(BW)) dut (
        .ui_clk_i(clk), .ui_reset_n_i(rst_n),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i), .error_o(error_o), .state_o(state_o)
    );

    int checks = 0;
    int fails  = 0;

    // UI-side monitor: records every handshake the DUT completes
    logic [DW-1:0] beat_q[$];
    logic [MW-1:0] bmask_q[$];
    logic          bend_q[$];
    logic [2:0]    cmd_q[$];
    logic [AW-1:0] caddr_q[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (app_wdf_wren_o && app_wdf_rdy_i) begin
                beat_q.push_back(app_wdf_data_o);
                bmask_q.push_back(app_wdf_mask_o);
                bend_q.push_back(app_wdf_end_o);
            end
            if (app_en_o && app_rdy_i) begin
                cmd_q.push_back(app_cmd_o);
                caddr_q.push_back(app_addr_o);
            end
        end
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_q.delete(); bmask_q.delete(); bend_q.delete();
        cmd_q.delete(); caddr_q.delete(); exp_q.delete();
    endtask

    // wdf_mode: 0 = always ready, 1 = toggle starting at 1, 2 = random; cmd_delay < 0 = random
    task automatic do_write(input logic [AW-1:0] addr, input logic [BW-1:0] data,
                            input logic [BW/8-1:0] mask, input int cmd_delay,
                            input int wdf_mode, output int ready_cyc);
        int cyc;
        bit done;
        logic [DW-1:0] exp_beat;
        clear_mon();
        for (int k = 0; k < BEATS; k++) exp_q.push_back(data[k*DW +: DW]);
        check("wr_req_ready", req_ready_o, 1);
        req_v_i = 1; req_write_i = 1; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
        tick();
        req_v_i = 0;
        cyc = 1; done = 0;
        while (!done && cyc < 200) begin
            app_rdy_i = (cmd_delay < 0) ? 1'($urandom_range(0, 1)) : (cyc > cmd_delay);
            case (wdf_mode)
                0:       app_wdf_rdy_i = 1'b1;
                1:       app_wdf_rdy_i = cyc[0];
                default: app_wdf_rdy_i = 1'($urandom_range(0, 1));
            endcase
            if (cyc == 1) begin
                check("wr_app_en_c1", app_en_o, 1);
                check("wr_cmd_c1", app_cmd_o, WR);
            end
            if (req_ready_o) done = 1;
            else begin
                tick();
                cyc++;
            end
        end
        ready_cyc = cyc;
        app_rdy_i = 0; app_wdf_rdy_i = 0;
        check("wr_done_in_budget", done, 1);
        check("wr_resp_v", resp_v_o, 0);
        check("wr_ncmd", cmd_q.size(), 1);
        if (cmd_q.size() > 0) begin
            check("wr_cmd", cmd_q[0], WR);
            check("wr_addr", caddr_q[0], addr);
        end
        check("wr_nbeats", beat_q.size(), BEATS);
        for (int k = 0; k < BEATS; k++) begin
            exp_beat = exp_q.pop_front();
            if (k < beat_q.size()) begin
                check("wr_beat_data", beat_q[k], exp_beat);
                check("wr_beat_mask", bmask_q[k], mask[k*MW +: MW]);
                check("wr_beat_end", bend_q[k], (k == BEATS - 1));
            end
        end
        check("wr_error", error_o, 0);
    endtask

    // Sends burst beat by beat; bad_end selects a beat whose end flag is wrong (-1 = none)
    task automatic do_read(input logic [AW-1:0] addr, input logic [BW-1:0] burst,
                           input int cmd_delay, input bit early, input int bad_end,
                           output logic [BW-1:0] exp_resp);
        int cyc, bi;
        bit cmd_ok, cmd_hs, send;
        logic [DW-1:0] seen_q[$];
        clear_mon();
        check("rd_req_ready", req_ready_o, 1);
        req_v_i = 1; req_write_i = 0; req_addr_i = addr; req_data_i = $urandom;
        tick();
        req_v_i = 0;
        cyc = 1; bi = 0; cmd_ok = 0;
        while (bi < BEATS && cyc < 200) begin
            app_rdy_i = (cmd_delay < 0) ? 1'($urandom_range(0, 1)) : (cyc > cmd_delay);
            if (cyc == 1) begin
                check("rd_app_en_c1", app_en_o, 1);
                check("rd_cmd_c1", app_cmd_o, RD);
            end
            send = (early && bi == 0 && cyc == 1) || (cmd_ok && $urandom_range(0, 2) != 0);
            app_rd_data_valid_i = send;
            app_rd_data_i = send ? burst[bi*DW +: DW] : DW'($urandom);
            app_rd_data_end_i = send && ((bi == BEATS - 1) != (bi == bad_end));
            if (send) seen_q.push_back(burst[bi*DW +: DW]);
            check("rd_resp_v_early", resp_v_o, 0);
            cmd_hs = app_en_o && app_rdy_i;
            tick();
            cyc++;
            if (cmd_hs) cmd_ok = 1;
            if (send) bi++;
        end
        app_rd_data_valid_i = 0; app_rd_data_end_i = 0; app_rdy_i = 0;
        exp_resp = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (seen_q.size() > 0) exp_resp[k*DW +: DW] = seen_q.pop_front();
        end
        check("rd_done_in_budget", bi, BEATS);
        check("rd_resp_v", resp_v_o, 1);
        check("rd_resp_data", resp_data_o, exp_resp);
        check("rd_req_ready_busy", req_ready_o, 0);
        check("rd_ncmd", cmd_q.size(), 1);
        if (cmd_q.size() > 0) begin
            check("rd_cmd", cmd_q[0], RD);
            check("rd_addr", caddr_q[0], addr);
        end
    endtask

    task automatic consume(input int hold, input logic [BW-1:0] exp_resp);
        for (int i = 0; i < hold; i++) begin
            check("hold_resp_v", resp_v_o, 1);
            check("hold_req_ready", req_ready_o, 0);
            check("hold_resp_data", resp_data_o, exp_resp);
            tick();
        end
        resp_yumi_i = 1;
        check("yumi_req_ready", req_ready_o, 0);
        tick();
        resp_yumi_i = 0;
        check("after_yumi_resp_v", resp_v_o, 0);
        check("after_yumi_req_ready", req_ready_o, 1);
    endtask

    initial begin
        int rc;
        logic [BW-1:0] resp;
        logic [BW-1:0] burst;

        // reset state
        #1;
        check("rst_req_ready", req_ready_o, 0);
        check("rst_app_en", app_en_o, 0);
        check("rst_wren", app_wdf_wren_o, 0);
        check("rst_wend", app_wdf_end_o, 0);
        check("rst_resp_v", resp_v_o, 0);
        check("rst_error", error_o, 0);
        check("rst_state", state_o, 0);
        #21 rst_n = 1;
        tick();
        check("post_rst_ready", req_ready_o, 1);

        // directed write, always-ready UI
        do_write(28'h100, 128'h44443333_22221111_DDDDCCCC_BBBBAAAA, '0, 0, 0, rc);
        check("wr1_ready_cycle", rc, 6);

        // command stalled 5 cycles, data ready toggling
        do_write(28'h140, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'h8421, 5, 1, rc);
        check("wr2_ready_cycle", rc, 9);

        // directed read with gaps
        do_read(28'h200, 128'h00000004_00000003_00000002_00000001, 0, 0, -1, resp);
        check("rd1_const", resp_data_o, 128'h00000004_00000003_00000002_00000001);
        consume(0, resp);

        // read whose first beat arrives before the command handshake
        burst = {$urandom, $urandom, $urandom, $urandom};
        do_read(28'h240, burst, 2, 1, -1, resp);

        // back-pressure: a new read waits while the response is held
        req_v_i = 1; req_write_i = 0; req_addr_i = 28'h280;
        consume(10, resp);
        burst = {$urandom, $urandom, $urandom, $urandom};
        do_read(28'h280, burst, 0, 0, -1, resp);
        consume(1, resp);

        // reset in the middle of a write, after two beats
        req_v_i = 1; req_write_i = 1; req_addr_i = 28'h300; req_data_i = {$urandom, $urandom, $urandom, $urandom};
        tick();
        req_v_i = 0; app_rdy_i = 1; app_wdf_rdy_i = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        check("midrst_app_en", app_en_o, 0);
        check("midrst_wren", app_wdf_wren_o, 0);
        check("midrst_wend", app_wdf_end_o, 0);
        check("midrst_req_ready", req_ready_o, 0);
        check("midrst_resp_v", resp_v_o, 0);
        check("midrst_state", state_o, 0);
        app_rdy_i = 0; app_wdf_rdy_i = 0;
        tick();
        #2 rst_n = 1;
        tick();
        do_write(28'h310, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 0, 0, rc);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            burst = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                do_write({24'($urandom), 4'h0}, burst, 16'($urandom), -1, 2, rc);
            end else begin
                do_read({24'($urandom), 4'h0}, burst, -1, 0, -1, resp);
                consume($urandom_range(0, 3), resp);
                check("rand_rd_error", error_o, 0);
            end
        end

        // wrong end flag on the 2nd read beat
        burst = {$urandom, $urandom, $urandom, $urandom};
        do_read(28'h400, burst, 0, 0, 1, resp);
        consume(0, resp);
        check("err_bad_end", error_o, ERR_EN);
        tick();
        tick();
        check("err_sticky", error_o, ERR_EN);

        // stray read beat while idle is dropped
        app_rd_data_valid_i = 1; app_rd_data_i = 32'hDEAD_BEEF;
        tick();
        app_rd_data_valid_i = 0;
        check("stray_state", state_o, 0);
        check("stray_ready", req_ready_o, 1);
        check("stray_resp_v", resp_v_o, 0);
        check("stray_resp_data", resp_data_o, resp);
        burst = {$urandom, $urandom, $urandom, $urandom};
        do_read(28'h440, burst, 0, 0, -1, resp);
        consume(0, resp);
        check("err_still_set", error_o, ERR_EN);

        // reset clears the sticky error
        rst_n = 0;
        #1;
        check("err_cleared", error_o, 0);
        #3 rst_n = 1;
        tick();
        check("final_ready", req_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
